// File: rtl/uart_byte_tx.sv
// 8N1 UART transmitter with a byte FIFO in front of it. Bytes go out LSB
// first. Every line level lasts 16 baud-enable strobes.
//
// state | meaning
// IDLE  | line high, waiting for a queued byte on a strobe edge
// START | start bit (low) for 16 strobes
// DATA  | data bits 0..7, 16 strobes each
// STOP  | stop bit (high) for 16 strobes, then chain the next byte or go idle
module uart_byte_tx #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic       iClock,
  input  logic       iReset,
  input  logic       iEn16xBaud,
  input  logic [7:0] iData,
  input  logic       iWrite,
  input  logic       iBufferReset,
  output logic       oSerialOut,
  output logic       oBusy,
  output logic       oBufferDataPresent,
  output logic       oBufferHalfFull,
  output logic       oBufferFull,
  output logic       oOverflow
);

  localparam int cAddrWidth = $clog2(FIFO_DEPTH);
  localparam logic [cAddrWidth:0] cFullCount = (cAddrWidth + 1)'(FIFO_DEPTH);
  localparam logic [cAddrWidth:0] cHalfCount = (cAddrWidth + 1)'(FIFO_DEPTH / 2);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } txState_t;

  // FIFO storage and bookkeeping
  logic [7:0]            fifoMem [FIFO_DEPTH];
  logic [cAddrWidth-1:0] rdPtr;
  logic [cAddrWidth-1:0] wrPtr;
  logic [cAddrWidth:0]   count;
  logic [cAddrWidth:0]   countNext;
  logic                  fifoFull;
  logic                  fifoEmpty;
  logic                  push;
  logic                  pop;
  logic [7:0]            headByte;

  // Transmit FSM
  txState_t   state;
  txState_t   stateNext;
  logic [3:0] tick;
  logic [3:0] tickNext;
  logic [2:0] bitIdx;
  logic [2:0] bitIdxNext;
  logic [2:0] bitIdxInc;
  logic [7:0] shiftReg;
  logic [7:0] shiftRegNext;
  logic       serialNext;

  assign fifoFull  = (count == cFullCount);
  assign fifoEmpty = (count == '0);
  assign headByte  = fifoMem[rdPtr];
  assign bitIdxInc = bitIdx + 3'd1;
  assign oBusy     = (state != IDLE);

  // A full FIFO still accepts a write when the FSM pops in the same cycle.
  always_comb begin
    push      = iWrite && (!fifoFull || pop);
    countNext = count;
    if (iBufferReset) begin
      countNext = '0;
    end else if (push && !pop) begin
      countNext = count + 1'b1;
    end else if (pop && !push) begin
      countNext = count - 1'b1;
    end
  end

  always_ff @(posedge iClock) begin
    if (!iReset) begin
      rdPtr              <= '0;
      wrPtr              <= '0;
      count              <= '0;
      oOverflow          <= 1'b0;
      oBufferDataPresent <= 1'b0;
      oBufferHalfFull    <= 1'b0;
      oBufferFull        <= 1'b0;
    end else begin
      count              <= countNext;
      oBufferDataPresent <= (countNext != '0);
      oBufferHalfFull    <= (countNext >= cHalfCount);
      oBufferFull        <= (countNext == cFullCount);
      if (iBufferReset) begin
        rdPtr     <= '0;
        wrPtr     <= '0;
        oOverflow <= 1'b0;
      end else begin
        if (push) begin
          wrPtr <= wrPtr + 1'b1;
        end
        if (pop) begin
          rdPtr <= rdPtr + 1'b1;
        end
        if (iWrite && !push) begin
          oOverflow <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset && !iBufferReset && push) begin
      fifoMem[wrPtr] <= iData;
    end
  end

  always_ff @(posedge iClock) begin
    if (!iReset) begin
      state      <= IDLE;
      tick       <= 4'd0;
      bitIdx     <= 3'd0;
      shiftReg   <= 8'd0;
      oSerialOut <= 1'b1;
    end else begin
      state      <= stateNext;
      tick       <= tickNext;
      bitIdx     <= bitIdxNext;
      shiftReg   <= shiftRegNext;
      oSerialOut <= serialNext;
    end
  end

  // Nothing advances without the strobe; the tick counter wraps 15 -> 0 on
  // each level change so every level is exactly 16 strobes long.
  always_comb begin
    stateNext    = state;
    tickNext     = tick;
    bitIdxNext   = bitIdx;
    shiftRegNext = shiftReg;
    serialNext   = oSerialOut;
    pop          = 1'b0;
    if (iEn16xBaud) begin
      case (state)
        IDLE: begin
          if (!fifoEmpty) begin
            pop          = 1'b1;
            shiftRegNext = headByte;
            serialNext   = 1'b0;
            tickNext     = 4'd0;
            stateNext    = START;
          end
        end
        START: begin
          tickNext = tick + 4'd1;
          if (tick == 4'd15) begin
            serialNext = shiftReg[0];
            bitIdxNext = 3'd0;
            stateNext  = DATA;
          end
        end
        DATA: begin
          tickNext = tick + 4'd1;
          if (tick == 4'd15) begin
            if (bitIdx == 3'd7) begin
              serialNext = 1'b1;
              stateNext  = STOP;
            end else begin
              bitIdxNext = bitIdxInc;
              serialNext = shiftReg[bitIdxInc];
            end
          end
        end
        STOP: begin
          tickNext = tick + 4'd1;
          if (tick == 4'd15) begin
            if (!fifoEmpty) begin
              pop          = 1'b1;
              shiftRegNext = headByte;
              serialNext   = 1'b0;
              stateNext    = START;
            end else begin
              stateNext = IDLE;
            end
          end
        end
        default: begin
          stateNext  = IDLE;
          serialNext = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_byte_tx.sv
// Directed bench for uart_byte_tx: framing, back-to-back frames, FIFO flags,
// overflow, slow strobe, flush and reset in the middle of a frame.
module tb_uart_byte_tx;

  logic       iClock = 1'b0;
  logic       iReset;
  logic       iEn16xBaud;
  logic [7:0] iData;
  logic       iWrite;
  logic       iBufferReset;
  logic       oSerialOut;
  logic       oBusy;
  logic       oBufferDataPresent;
  logic       oBufferHalfFull;
  logic       oBufferFull;
  logic       oOverflow;

  int checks = 0;
  int failures = 0;
  int strobeDiv = 0;
  int divCnt = 0;

  uart_byte_tx #(.FIFO_DEPTH(16)) dut (
    .iClock(iClock),
    .iReset(iReset),
    .iEn16xBaud(iEn16xBaud),
    .iData(iData),
    .iWrite(iWrite),
    .iBufferReset(iBufferReset),
    .oSerialOut(oSerialOut),
    .oBusy(oBusy),
    .oBufferDataPresent(oBufferDataPresent),
    .oBufferHalfFull(oBufferHalfFull),
    .oBufferFull(oBufferFull),
    .oOverflow(oOverflow)
  );

  always #5 iClock = ~iClock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance to the next falling edge and set the strobe for the coming rising edge.
  task automatic stepCycle();
    @(negedge iClock);
    divCnt++;
    if (strobeDiv == 0) iEn16xBaud = 1'b0;
    else iEn16xBaud = ((divCnt % strobeDiv) == 0);
  endtask

  task automatic startStrobes(input int div);
    strobeDiv = div;
    divCnt = 0;
    iEn16xBaud = 1'b1;
  endtask

  task automatic stopStrobes();
    strobeDiv = 0;
    iEn16xBaud = 1'b0;
  endtask

  task automatic writeByte(input logic [7:0] b);
    iData = b;
    iWrite = 1'b1;
    stepCycle();
    iWrite = 1'b0;
  endtask

  task automatic checkFlags(input string tag, input logic [3:0] expected);
    check(tag, {oBufferDataPresent, oBufferHalfFull, oBufferFull, oOverflow}, expected);
  endtask

  // Called at the falling edge just before the start-bit edge; samples every
  // cycle of the frame (10 levels of cpl cycles each).
  task automatic expectFrame(input logic [7:0] b, input int cpl, input logic expPresent,
                             input int flushAt, input string tag);
    int lineErrs = 0;
    int busyErrs = 0;
    int k;
    logic lvl;
    for (int i = 0; i < 10 * cpl; i++) begin
      stepCycle();
      iBufferReset = (i == flushAt);
      k = i / cpl;
      if (k == 0) lvl = 1'b0;
      else if (k == 9) lvl = 1'b1;
      else lvl = b[k-1];
      if (oSerialOut !== lvl) lineErrs++;
      if (oBusy !== 1'b1) busyErrs++;
      if (i == 0) check({tag, " present"}, oBufferDataPresent, expPresent);
      if (flushAt >= 0 && i == flushAt + 1) check({tag, " flushed"}, oBufferDataPresent, 1'b0);
    end
    iBufferReset = 1'b0;
    check({tag, " line"}, lineErrs, 0);
    check({tag, " busy"}, busyErrs, 0);
  endtask

  initial begin
    int idleErrs;
    int n;
    logic [3:0] expFlags;

    iReset = 1'b0;
    iWrite = 1'b0;
    iData = 8'h00;
    iBufferReset = 1'b0;
    iEn16xBaud = 1'b0;
    repeat (3) stepCycle();
    check("reset line", oSerialOut, 1'b1);
    check("reset busy", oBusy, 1'b0);
    checkFlags("reset flags", 4'b0000);
    iReset = 1'b1;
    stepCycle();

    // Single byte with the strobe held high
    startStrobes(1);
    writeByte(8'hA5);
    check("a5 queued present", oBufferDataPresent, 1'b1);
    check("a5 queued line", oSerialOut, 1'b1);
    check("a5 queued busy", oBusy, 1'b0);
    expectFrame(8'hA5, 16, 1'b0, -1, "a5");
    stepCycle();
    check("a5 end busy", oBusy, 1'b0);
    check("a5 end line", oSerialOut, 1'b1);

    // Three frames back to back
    stopStrobes();
    writeByte(8'h00);
    writeByte(8'hFF);
    writeByte(8'h55);
    checkFlags("b2b queued", 4'b1000);
    startStrobes(1);
    expectFrame(8'h00, 16, 1'b1, -1, "b2b 00");
    expectFrame(8'hFF, 16, 1'b1, -1, "b2b ff");
    expectFrame(8'h55, 16, 1'b0, -1, "b2b 55");
    stepCycle();
    check("b2b end busy", oBusy, 1'b0);

    // Fill to full and overflow with no strobe
    stopStrobes();
    for (int k = 1; k <= 17; k++) begin
      iData = 8'(k);
      iWrite = 1'b1;
      stepCycle();
      expFlags = {1'b1, (k >= 8), (k >= 16), (k == 17)};
      checkFlags($sformatf("fill %0d", k), expFlags);
    end
    iWrite = 1'b0;
    check("fill busy", oBusy, 1'b0);
    iBufferReset = 1'b1;
    stepCycle();
    iBufferReset = 1'b0;
    checkFlags("flush flags", 4'b0000);

    // Write into a full FIFO in the same cycle as a pop is accepted
    for (int k = 1; k <= 16; k++) writeByte(8'(k));
    checkFlags("refill", 4'b1110);
    iData = 8'hEE;
    iWrite = 1'b1;
    startStrobes(1);
    stepCycle();
    iWrite = 1'b0;
    checkFlags("full push+pop", 4'b1110);
    check("full push+pop busy", oBusy, 1'b1);
    check("full push+pop line", oSerialOut, 1'b0);
    iBufferReset = 1'b1;
    stepCycle();
    iBufferReset = 1'b0;
    checkFlags("full flush", 4'b0000);
    n = 0;
    while (oBusy && n < 200) begin
      stepCycle();
      n++;
    end
    check("drain busy", oBusy, 1'b0);

    // Slow strobe, every fourth cycle
    stopStrobes();
    stepCycle();
    writeByte(8'h80);
    startStrobes(4);
    expectFrame(8'h80, 64, 1'b0, -1, "slow");
    stepCycle();
    check("slow end busy", oBusy, 1'b0);

    // Flush during the first frame's data bits
    stopStrobes();
    writeByte(8'h3C);
    writeByte(8'h11);
    writeByte(8'h22);
    writeByte(8'h33);
    startStrobes(1);
    expectFrame(8'h3C, 16, 1'b1, 40, "flush frame");
    idleErrs = 0;
    for (int i = 0; i < 20; i++) begin
      stepCycle();
      if (oSerialOut !== 1'b1 || oBusy !== 1'b0) idleErrs++;
    end
    check("flush idle", idleErrs, 0);

    // Reset in the middle of a start bit
    stopStrobes();
    writeByte(8'hC3);
    writeByte(8'h5A);
    startStrobes(1);
    repeat (5) stepCycle();
    check("pre-reset line", oSerialOut, 1'b0);
    check("pre-reset busy", oBusy, 1'b1);
    iReset = 1'b0;
    stepCycle();
    check("mid reset line", oSerialOut, 1'b1);
    check("mid reset busy", oBusy, 1'b0);
    checkFlags("mid reset flags", 4'b0000);
    iReset = 1'b1;
    stopStrobes();
    stepCycle();
    check("post reset idle", oSerialOut, 1'b1);
    writeByte(8'h96);
    startStrobes(1);
    expectFrame(8'h96, 16, 1'b0, -1, "post reset");
    stepCycle();
    check("post reset end busy", oBusy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
